// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if : signal bundle between the serial pin, the receiver and the
//              program loader.
//   rx          line -> receiver   raw serial input, idle high, async to clk
//   data_rx     receiver -> loader last good received byte
//   data_rx_seq receiver -> loader toggles once per good byte
//   frame_err   receiver -> loader one-cycle pulse on a bad stop bit
//   busy        receiver -> loader high while a frame is in progress
// master : the receiver side (drives the byte outputs)
// slave  : the line driver / consumer side
// ---------------------------------------------------------------------------
interface uart_rx_if;
    logic       rx;
    logic [7:0] data_rx;
    logic       data_rx_seq;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output data_rx,
        output data_rx_seq,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  data_rx,
        input  data_rx_seq,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 asynchronous serial receiver feeding the program loader.
//
// Ports
//   clk    system clock, all state changes on the rising edge
//   reset  asynchronous, active-high reset
//   bus    uart_rx_if.master
//            rx          raw serial line (idle high, asynchronous)
//            data_rx     last good received byte
//            data_rx_seq toggles once per good byte (toggle handshake)
//            frame_err   one-cycle pulse when the stop bit reads low
//            busy        high whenever the FSM is not IDLE
//
// The consumer detects a new byte by comparing data_rx_seq against its own
// copy; there is no back-pressure, so a missed toggle silently loses a byte.
// data_rx and data_rx_seq update on the same edge and data_rx is then held
// until the next good byte.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic        clk,
    input  logic        reset,
    uart_rx_if.master   bus
);

    // A half-bit load of CLKS_PER_BIT/2-1 needs at least a few cycles per bit.
    if (CLKS_PER_BIT < 4) begin : g_param_check
        $error("uart_rx: CLKS_PER_BIT must be >= 4");
    end

    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t HALF_LOAD = cnt_t'(CLKS_PER_BIT / 2 - 1);
    localparam cnt_t FULL_LOAD = cnt_t'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    // Two-flop synchronizer; every decision below looks at rx_s_q only.
    logic rx_m_q, rx_s_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            rx_m_q <= bus.rx;
            rx_s_q <= rx_m_q;
        end
    end

    state_t     state_q, state_d;
    cnt_t       cnt_q,   cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] data_q,  data_d;
    logic       seq_q,   seq_d;
    logic       ferr_q,  ferr_d;

    logic tick;
    assign tick = (cnt_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            seq_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            seq_q     <= seq_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        seq_d     = seq_q;
        ferr_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Half-bit load puts every later sample in mid-bit.
                if (!rx_s_q) begin
                    cnt_d   = HALF_LOAD;
                    state_d = START;
                end
            end

            START: begin
                if (tick) begin
                    if (!rx_s_q) begin
                        cnt_d     = FULL_LOAD;
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end else begin
                        // Line went back high before mid start bit: glitch.
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end

            DATA: begin
                if (tick) begin
                    shift_d = {rx_s_q, shift_q[7:1]};  // LSB arrives first
                    cnt_d   = FULL_LOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end

            STOP: begin
                if (tick) begin
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        seq_d   = ~seq_q;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end

            BREAK: begin
                // Wait out a held-low line so a break reports only once.
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.data_rx     = data_q;
    assign bus.data_rx_seq = seq_q;
    assign bus.frame_err   = ferr_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int CPB = 8;
    // Busy cycles per frame: half start bit + 8 data bits + stop bit.
    localparam int FRAME_BUSY = CPB / 2 + 9 * CPB;
    // Edges from driving the pin low (just before an edge) to the toggle:
    // 1 edge to register the pin, 2 more through the synchronizer... the
    // sampling edge plus 2 + CPB/2 + 9*CPB.
    localparam int TOGGLE_LAT = 1 + 2 + CPB / 2 + 9 * CPB;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    uart_rx_if u_if ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    int checks = 0;
    int errors = 0;

    // Monitor-owned event counters; tests work on differences.
    int cyc          = 0;
    int n_tog        = 0;
    int n_fe         = 0;
    int n_busy       = 0;
    int last_tog_cyc = 0;
    logic prev_seq   = 1'b0;
    logic prev_fe    = 1'b0;

    logic [7:0] exp_q[$];

    // Scoreboard: every toggle pops one expected byte.
    always @(posedge clk) begin
        logic [7:0] exp_b;
        cyc = cyc + 1;
        #1;
        if (reset) begin
            prev_seq = u_if.data_rx_seq;
            prev_fe  = 1'b0;
        end else begin
            if (u_if.busy) n_busy = n_busy + 1;
            if (u_if.frame_err) begin
                checks = checks + 1;
                if (prev_fe) begin
                    errors = errors + 1;
                    $display("FAIL fe_width: frame_err high on 2 consecutive cycles at cyc %0d, want 1-cycle pulse", cyc);
                end else begin
                    n_fe = n_fe + 1;
                end
            end
            prev_fe = u_if.frame_err;
            if (u_if.data_rx_seq !== prev_seq) begin
                n_tog        = n_tog + 1;
                last_tog_cyc = cyc;
                checks       = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL sb_unexpected: toggle with data_rx=%02h, want no byte", u_if.data_rx);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (u_if.data_rx !== exp_b) begin
                        errors = errors + 1;
                        $display("FAIL sb_data: data_rx=%02h, want %02h", u_if.data_rx, exp_b);
                    end
                end
            end
            prev_seq = u_if.data_rx_seq;
        end
    end

    task automatic do_reset();
        reset   = 1'b1;
        u_if.rx = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Drives one 8N1 frame starting at the current negedge; the line is
    // left at the stop level afterwards.
    task automatic send_byte(input logic [7:0] b, input logic stop, input bit good);
        if (good) exp_q.push_back(b);
        u_if.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            u_if.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        u_if.rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        int t0, f0, b0;
        reset   = 1'b1;
        u_if.rx = 1'b1;
        repeat (2) @(negedge clk);
        checks = checks + 4;
        if (u_if.data_rx !== 8'h00) begin errors++; $display("FAIL rst_data: got %02h, want 00", u_if.data_rx); end
        if (u_if.data_rx_seq !== 1'b0) begin errors++; $display("FAIL rst_seq: got %b, want 0", u_if.data_rx_seq); end
        if (u_if.frame_err !== 1'b0) begin errors++; $display("FAIL rst_fe: got %b, want 0", u_if.frame_err); end
        if (u_if.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, want 0", u_if.busy); end
        reset = 1'b0;
        t0 = n_tog; f0 = n_fe; b0 = n_busy;
        repeat (200) @(negedge clk);
        checks = checks + 4;
        if (n_tog - t0 != 0) begin errors++; $display("FAIL idle_tog: got %0d toggles, want 0", n_tog - t0); end
        if (n_fe - f0 != 0) begin errors++; $display("FAIL idle_fe: got %0d pulses, want 0", n_fe - f0); end
        if (n_busy - b0 != 0) begin errors++; $display("FAIL idle_busy: busy high %0d cycles, want 0", n_busy - b0); end
        if (u_if.data_rx !== 8'h00) begin errors++; $display("FAIL idle_data: got %02h, want 00", u_if.data_rx); end
    endtask

    task automatic test_single();
        int t0, b0, c0;
        do_reset();
        t0 = n_tog; b0 = n_busy; c0 = cyc;
        send_byte(8'hA5, 1'b1, 1'b1);
        repeat (CPB) @(negedge clk);
        checks = checks + 6;
        if (n_tog - t0 != 1) begin errors++; $display("FAIL single_tog: got %0d toggles, want 1", n_tog - t0); end
        if (u_if.data_rx_seq !== 1'b1) begin errors++; $display("FAIL single_seq: got %b, want 1", u_if.data_rx_seq); end
        if (u_if.data_rx !== 8'hA5) begin errors++; $display("FAIL single_data: got %02h, want a5", u_if.data_rx); end
        if (last_tog_cyc - c0 != TOGGLE_LAT) begin errors++; $display("FAIL single_lat: toggle %0d edges after rx fall, want %0d", last_tog_cyc - c0, TOGGLE_LAT); end
        if (n_busy - b0 != FRAME_BUSY) begin errors++; $display("FAIL single_busy: busy %0d cycles, want %0d", n_busy - b0, FRAME_BUSY); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL single_sb: %0d bytes outstanding, want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int t0;
        do_reset();
        t0 = n_tog;
        send_byte(8'h00, 1'b1, 1'b1);
        send_byte(8'hFF, 1'b1, 1'b1);
        send_byte(8'h3C, 1'b1, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        checks = checks + 4;
        if (n_tog - t0 != 3) begin errors++; $display("FAIL b2b_tog: got %0d toggles, want 3", n_tog - t0); end
        if (u_if.data_rx_seq !== 1'b1) begin errors++; $display("FAIL b2b_seq: got %b, want 1", u_if.data_rx_seq); end
        if (u_if.data_rx !== 8'h3C) begin errors++; $display("FAIL b2b_data: got %02h, want 3c", u_if.data_rx); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_sb: %0d bytes outstanding, want 0", exp_q.size()); end
    endtask

    task automatic test_glitch();
        int t0, f0, b0;
        do_reset();
        t0 = n_tog; f0 = n_fe; b0 = n_busy;
        u_if.rx = 1'b0;
        repeat (3) @(negedge clk);
        u_if.rx = 1'b1;
        repeat (CPB) @(negedge clk);
        checks = checks + 5;
        if (u_if.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b, want 0", u_if.busy); end
        if (n_busy - b0 != CPB / 2) begin errors++; $display("FAIL glitch_start: busy %0d cycles, want %0d", n_busy - b0, CPB / 2); end
        if (n_tog - t0 != 0) begin errors++; $display("FAIL glitch_tog: got %0d toggles, want 0", n_tog - t0); end
        if (n_fe - f0 != 0) begin errors++; $display("FAIL glitch_fe: got %0d pulses, want 0", n_fe - f0); end
        if (u_if.data_rx_seq !== 1'b0) begin errors++; $display("FAIL glitch_seq: got %b, want 0", u_if.data_rx_seq); end
    endtask

    task automatic test_frame_err();
        int t0, f0;
        do_reset();
        t0 = n_tog; f0 = n_fe;
        send_byte(8'h55, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        u_if.rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checks = checks + 5;
        if (n_fe - f0 != 1) begin errors++; $display("FAIL ferr_count: got %0d pulses, want 1", n_fe - f0); end
        if (n_tog - t0 != 0) begin errors++; $display("FAIL ferr_tog: got %0d toggles, want 0", n_tog - t0); end
        if (u_if.data_rx_seq !== 1'b0) begin errors++; $display("FAIL ferr_seq: got %b, want 0", u_if.data_rx_seq); end
        if (u_if.data_rx !== 8'h00) begin errors++; $display("FAIL ferr_data: got %02h, want 00", u_if.data_rx); end
        if (u_if.busy !== 1'b0) begin errors++; $display("FAIL ferr_busy: got %b, want 0", u_if.busy); end
        send_byte(8'h81, 1'b1, 1'b1);
        repeat (CPB) @(negedge clk);
        checks = checks + 5;
        if (n_tog - t0 != 1) begin errors++; $display("FAIL ferr_next_tog: got %0d toggles, want 1", n_tog - t0); end
        if (u_if.data_rx !== 8'h81) begin errors++; $display("FAIL ferr_next_data: got %02h, want 81", u_if.data_rx); end
        if (u_if.data_rx_seq !== 1'b1) begin errors++; $display("FAIL ferr_next_seq: got %b, want 1", u_if.data_rx_seq); end
        if (n_fe - f0 != 1) begin errors++; $display("FAIL ferr_next_fe: got %0d pulses, want 1", n_fe - f0); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL ferr_sb: %0d bytes outstanding, want 0", exp_q.size()); end
    endtask

    task automatic test_reset_abort();
        int t0, f0;
        logic [7:0] ab;
        do_reset();
        send_byte(8'h5A, 1'b1, 1'b1);
        repeat (CPB) @(negedge clk);
        checks = checks + 1;
        if (u_if.data_rx !== 8'h5A) begin errors++; $display("FAIL abort_pre: got %02h, want 5a", u_if.data_rx); end
        // Partial frame: start + bits 0..3, reset half way through bit 4.
        ab = 8'hC3;
        u_if.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            u_if.rx = ab[i];
            repeat ((i == 4) ? CPB / 2 : CPB) @(negedge clk);
        end
        reset   = 1'b1;
        u_if.rx = 1'b1;
        #1;
        checks = checks + 3;
        if (u_if.data_rx_seq !== 1'b0) begin errors++; $display("FAIL abort_seq: got %b, want 0", u_if.data_rx_seq); end
        if (u_if.data_rx !== 8'h00) begin errors++; $display("FAIL abort_data: got %02h, want 00", u_if.data_rx); end
        if (u_if.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, want 0", u_if.busy); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        t0 = n_tog; f0 = n_fe;
        repeat (3 * CPB) @(negedge clk);
        checks = checks + 2;
        if (n_tog - t0 != 0) begin errors++; $display("FAIL abort_tog: got %0d toggles, want 0", n_tog - t0); end
        if (n_fe - f0 != 0) begin errors++; $display("FAIL abort_fe: got %0d pulses, want 0", n_fe - f0); end
        send_byte(8'h12, 1'b1, 1'b1);
        repeat (CPB) @(negedge clk);
        checks = checks + 4;
        if (n_tog - t0 != 1) begin errors++; $display("FAIL abort_next_tog: got %0d toggles, want 1", n_tog - t0); end
        if (u_if.data_rx_seq !== 1'b1) begin errors++; $display("FAIL abort_next_seq: got %b, want 1", u_if.data_rx_seq); end
        if (u_if.data_rx !== 8'h12) begin errors++; $display("FAIL abort_next_data: got %02h, want 12", u_if.data_rx); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL abort_sb: %0d bytes outstanding, want 0", exp_q.size()); end
    endtask

    initial begin
        u_if.rx = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors = errors + 1;
        $display("FAIL timeout: simulation still running at %0t, want completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
